// File: rtl/flappy_pkg.sv
// Shared types and defaults for the Flappy Bird matrix game.
// Used by the controller, bird-cell logic and pipe scroller.
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      LOST = 2'b10
   } state_t;

   localparam int          ROWS          = 8;
   localparam int          DEF_START_ROW = 3;
   localparam logic [10:0] DEF_TICK_MAX  = 11'd1791;

   function automatic logic [ROWS-1:0] onehot(input logic [2:0] r);
      logic [ROWS-1:0] v;
      v    = '0;
      v[r] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/flappy_tick_gen.sv
// Game-step counter; tick is a decode of the registered count.
// Count is held at zero whenever disabled or cleared.
module flappy_tick_gen
   import flappy_pkg::*;
#(
   parameter logic [10:0] TICK_MAX = DEF_TICK_MAX
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [10:0] count;

   always_ff @(posedge clock) begin
      if (reset || clr || !en)
         count <= '0;
      else if (count == TICK_MAX)
         count <= '0;
      else
         count <= count + 11'd1;
   end

   assign tick = en && (count == TICK_MAX);

endmodule

// File: rtl/flappy_game_ctrl.sv
// Flappy Bird game sequencer: state machine, bird position,
// flap resolution, collision detection and score keeping.
module flappy_game_ctrl
   import flappy_pkg::*;
#(
   parameter logic [10:0] TICK_MAX  = DEF_TICK_MAX,
   parameter int          START_ROW = DEF_START_ROW
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       KEY0,
   input  logic [7:0] pipeCol,
   output logic       tick,
   output logic [7:0] birdRow,
   output logic       lossDetect,
   output logic [7:0] score,
   output logic [1:0] gameState
);

   state_t     state, state_n;
   logic [2:0] row, row_n;
   logic [7:0] score_q, score_n;
   logic       fp, fp_n;
   logic       key_q;
   logic       key_rise;
   logic       flap, ground;
   logic [2:0] next_row;

   assign key_rise = KEY0 & ~key_q;

   flappy_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
      .clock (clock),
      .reset (reset),
      .en    (state == PLAY),
      .clr   (state_n != PLAY),
      .tick  (tick)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         row     <= 3'(START_ROW);
         score_q <= '0;
         fp      <= 1'b0;
         key_q   <= 1'b0;
      end else begin
         state   <= state_n;
         row     <= row_n;
         score_q <= score_n;
         fp      <= fp_n;
         key_q   <= KEY0;
      end
   end

   always_comb begin
      state_n  = state;
      row_n    = row;
      score_n  = score_q;
      fp_n     = fp;
      flap     = 1'b0;
      ground   = 1'b0;
      next_row = row;
      unique case (state)
         IDLE: begin
            row_n = 3'(START_ROW);
            fp_n  = 1'b0;
            if (key_rise) begin
               state_n = PLAY;
               score_n = '0;
            end
         end
         PLAY: begin
            if (key_rise)
               fp_n = 1'b1;
            if (tick) begin
               fp_n = 1'b0;
               flap = fp | key_rise;
               if (flap)
                  next_row = (row == 3'd7) ? 3'd7 : row + 3'd1;
               else if (row == 3'd0)
                  ground = 1'b1;
               else
                  next_row = row - 3'd1;
               row_n = next_row;
               // a ground hit leaves the bird parked on row 0
               if (ground || pipeCol[next_row]) begin
                  state_n = LOST;
               end else if ((|pipeCol) && (score_q != 8'hFF)) begin
                  score_n = score_q + 8'd1;
               end
            end
         end
         LOST: begin
            fp_n = 1'b0;
            if (key_rise) begin
               state_n = IDLE;
               row_n   = 3'(START_ROW);
            end
         end
         default: begin
            state_n = IDLE;
            row_n   = 3'(START_ROW);
            fp_n    = 1'b0;
         end
      endcase
   end

   assign birdRow    = onehot(row);
   assign score      = score_q;
   assign lossDetect = (state == LOST);
   assign gameState  = state;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Scoreboard bench for flappy_game_ctrl with a step-level game model.
// Directed scenarios are followed by randomized play.
module tb_flappy_game_ctrl;

   localparam int TM = 3;
   localparam int SR = 3;

   typedef struct packed {
      logic       tick;
      logic [7:0] bird;
      logic       loss;
      logic [7:0] score;
      logic [1:0] gs;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       KEY0 = 1'b0;
   logic [7:0] pipeCol = 8'h00;
   logic       tick;
   logic [7:0] birdRow;
   logic       lossDetect;
   logic [7:0] score;
   logic [1:0] gameState;

   int checks = 0;
   int errors = 0;
   exp_t q[$];

   // model of the game: 0 idle, 1 play, 2 lost
   int ms, mc, mrow, msc;
   bit mfp, mkq;

   flappy_game_ctrl #(.TICK_MAX(11'(TM)), .START_ROW(SR)) dut (
      .clock      (clock),
      .reset      (reset),
      .KEY0       (KEY0),
      .pipeCol    (pipeCol),
      .tick       (tick),
      .birdRow    (birdRow),
      .lossDetect (lossDetect),
      .score      (score),
      .gameState  (gameState)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   function automatic exp_t expected();
      exp_t e;
      e.tick  = (ms == 1) && (mc == TM);
      e.bird  = 8'h01 << mrow;
      e.loss  = (ms == 2);
      e.score = 8'(msc);
      e.gs    = 2'(ms);
      return e;
   endfunction

   task automatic model(input bit r, input bit k, input logic [7:0] p);
      bit kr;
      int nr;
      if (r) begin
         ms = 0; mc = 0; mrow = SR; msc = 0; mfp = 0; mkq = 0;
         return;
      end
      kr  = k && !mkq;
      mkq = k;
      if (ms == 0) begin
         mrow = SR; mfp = 0; mc = 0;
         if (kr) begin ms = 1; msc = 0; end
      end else if (ms == 2) begin
         mc = 0;
         if (kr) begin ms = 0; mrow = SR; end
      end else if (mc != TM) begin
         mc++;
         if (kr) mfp = 1;
      end else begin
         nr = (mfp || kr) ? ((mrow < 7) ? mrow + 1 : 7) : mrow - 1;
         if (nr < 0) begin
            ms = 2;
         end else if (p[nr]) begin
            ms = 2; mrow = nr;
         end else begin
            mrow = nr;
            if (p != 0 && msc < 255) msc++;
         end
         mfp = 0; mc = 0;
      end
   endtask

   task automatic step(input bit k, input logic [7:0] p, input bit r);
      KEY0 = k; pipeCol = p; reset = r;
      @(posedge clock);
      model(r, k, p);
      q.push_back(expected());
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0);
   endtask

   task automatic rst();
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);
   endtask

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if ({tick, birdRow, lossDetect, score, gameState} !== e) begin
               errors++;
               $display("FAIL cycle @%0t: tick=%b bird=%h loss=%b score=%0d gs=%b expected tick=%b bird=%h loss=%b score=%0d gs=%b",
                        $time, tick, birdRow, lossDetect, score, gameState,
                        e.tick, e.bird, e.loss, e.score, e.gs);
            end
         end
      end
   end

   initial begin
      bit k;
      logic [7:0] p;
      // idle after reset
      rst();
      idle(10);
      chk("reset_bird", birdRow, 8'h08);
      chk("reset_gs", 8'(gameState), 8'h00);
      // fall to the ground
      step(1, 8'h00, 0);
      chk("enter_play", 8'(gameState), 8'h01);
      idle(16);
      chk("ground_loss", 8'(lossDetect), 8'h01);
      chk("ground_bird", birdRow, 8'h01);
      chk("ground_score", score, 8'h00);
      // climb to the ceiling
      rst();
      step(1, 8'h00, 0);
      step(0, 8'h00, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 8'h00, 0);
         idle(3);
      end
      chk("ceiling_bird", birdRow, 8'h80);
      chk("ceiling_noloss", 8'(lossDetect), 8'h00);
      // press landing on the tick cycle
      rst();
      step(1, 8'h00, 0);
      idle(3);
      step(1, 8'h00, 0);
      chk("tick_flap", birdRow, 8'h10);
      idle(4);
      chk("fp_cleared", birdRow, 8'h08);
      // pass a pipe, then hit one
      rst();
      step(1, 8'h00, 0);
      idle(3);
      step(0, 8'hF3, 0);
      chk("pipe_pass_bird", birdRow, 8'h04);
      chk("pipe_pass_score", score, 8'h01);
      idle(3);
      step(0, 8'h02, 0);
      idle(1);
      chk("pipe_hit_loss", 8'(lossDetect), 8'h01);
      chk("pipe_hit_bird", birdRow, 8'h02);
      chk("pipe_hit_score", score, 8'h01);
      // lost -> idle -> play -> reset
      step(1, 8'h00, 0);
      chk("relaunch_bird", birdRow, 8'h08);
      chk("relaunch_score", score, 8'h01);
      step(0, 8'h00, 0);
      step(1, 8'h00, 0);
      chk("replay_score", score, 8'h00);
      idle(2);
      step(0, 8'h00, 1);
      chk("midreset_gs", 8'(gameState), 8'h00);
      chk("midreset_bird", birdRow, 8'h08);
      step(0, 8'h00, 0);
      // random play
      for (int i = 0; i < 3000; i++) begin
         k = ($urandom_range(0, 2) == 0);
         p = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         step(k, p, $urandom_range(0, 499) == 0);
      end
      @(negedge clock);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Central game sequencer for the 8x8 Flappy Bird matrix. Owns the game state machine (IDLE/PLAY/LOST), generates the shared game-step tick, holds the bird's vertical position, resolves flaps, detects ground and pipe collisions, and keeps the score. Drives the bird-cell logic and the pipe scroller; the LED driver consumes its position and state outputs.

## Interface

Parameters:
- TICK_MAX, 11'd1791: last value of the tick counter. Step period is TICK_MAX+1 clocks.
- START_ROW, 3: bird row index on reset and on every entry to IDLE. Row 0 is the bottom, row 7 the top.

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; overrides all other inputs
- KEY0  in  1  flap button, active-high, already synchronized; only its rising edge is used
- pipeCol  in  8  pipe occupancy of the bird's column; bit i = red at row i; valid on tick cycles
- tick  out  1  one-cycle game-step pulse, PLAY only
- birdRow  out  8  one-hot bird position; bit i = bird at row i
- lossDetect  out  1  high while in LOST
- score  out  8  pipes cleared, saturates at 255
- gameState  out  2  00 IDLE, 01 PLAY, 10 LOST; 11 unused

## Operation

- KEY0 edge detect: keyRise = KEY0 & ~KEY0_q. KEY0_q is a register that resets to 0.
- IDLE:
  - birdRow = one-hot(START_ROW); counter held at 0.
  - On keyRise -> PLAY. Also clear score and flapPending.
- PLAY:
  - counter runs 0..TICK_MAX, then wraps to 0.
  - tick = (counter == TICK_MAX). This is a combinational decode of registered state.
  - keyRise sets flapPending. flapPending clears on each tick.
- On a tick, compute nextRow:
  - flap = flapPending | keyRise. A keyRise on the tick cycle counts for this tick.
  - If flap: nextRow = row+1, saturating at 7 (a flap at row 7 stays at 7, no loss).
  - If no flap: nextRow = row-1. If row==0, this is a ground hit and the game is lost.
  - If ground hit, or pipeCol[nextRow]==1: go to LOST. birdRow is updated to nextRow, or stays at 0 on a ground hit. score holds.
  - Otherwise: birdRow <= nextRow. If pipeCol != 0, score <= score+1, saturating at 255.
- LOST:
  - counter held at 0; tick=0; birdRow and score frozen.
  - On keyRise -> IDLE. birdRow reloads START_ROW; score is kept for display.
- gameState 11: illegal. Next state is IDLE.
- reset: state IDLE, counter 0, birdRow one-hot(START_ROW) (8'h08 at default), score 0, flapPending 0, KEY0_q 0, tick 0, lossDetect 0, gameState 00.

## Timing

- All state updates on posedge clock; no combinational path from KEY0 or pipeCol to any output.
- First tick occurs TICK_MAX+1 clocks after the edge that enters PLAY. Subsequent ticks are every TICK_MAX+1 clocks.
- birdRow, score, and state reflect a tick one cycle after tick is high.
- lossDetect rises on the cycle after the fatal tick.
- Entry to IDLE or PLAY takes effect on the edge after keyRise.
- reset asserted mid-PLAY: all outputs hold reset values from the next edge and stay there while reset is held.
- Counter width: 11 bits. TICK_MAX must be ≥ 1.

## Structure

- Package flappy_pkg holds:
  - state enum (IDLE, PLAY, LOST) with its 2-bit encoding
  - ROWS = 8
  - default START_ROW and TICK_MAX, shared with the bird-cell logic and the pipe scroller
- Sub-module flappy_tick_gen: 11-bit counter plus tick decode, with an enable (= PLAY) and a synchronous clear. Everything else lives in flappy_game_ctrl.

## Test plan

Bench uses TICK_MAX=3.

1. Reset, then idle for 10 cycles with no keyRise -> birdRow=8'h08, score=0, tick never high, gameState=00, lossDetect=0.
2. keyRise in IDLE, pipeCol=0, no further presses -> gameState=01. tick pulses 4, 8, 12, 16 cycles after entry. birdRow goes 08 -> 04 -> 02 -> 01. On the 4th tick: ground hit, lossDetect=1 on the next cycle, score=0.
3. Flap on every step from row 3 -> birdRow climbs to 8'h80 and stays 8'h80 on further flaps; no loss.
4. keyRise on the exact tick cycle, bird at row 3 -> bird moves to row 4 (8'h10), not row 2; flapPending is 0 afterwards.
5. Bird at row 3, no flap, pipeCol=8'hF3 on tick (gap at rows 2-3) -> birdRow=8'h04, score=1. Next tick with pipeCol=8'h02 (bird falls to row 1) -> LOST; score stays 1, birdRow=8'h02.
6. In LOST, keyRise -> IDLE with birdRow=8'h08, score still 1. keyRise again -> PLAY with score=0. Assert reset mid-PLAY -> all outputs return to reset values on the next edge.
